// File: rtl/mac_pkg.sv
// Shared TX MAC definitions.
// Contents:
//   TX_IFG_WORDS  : default idle gap (32-bit words) forced after each frame
//   AXIS_DATA_W   : AXI-Stream data width of the MAC datapath
//   AXIS_KEEP_W   : matching tkeep width
//   arb_state_t   : state encoding of the TX input arbiter
//   axi_stream_t  : one AXI-Stream beat (payload only, no handshake)
package mac_pkg;

  localparam int TX_IFG_WORDS = 3;
  localparam int AXIS_DATA_W  = 32;
  localparam int AXIS_KEEP_W  = AXIS_DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    GAP  = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic [AXIS_DATA_W-1:0] tdata;
    logic [AXIS_KEEP_W-1:0] tkeep;
    logic                   tlast;
  } axi_stream_t;

endpackage

// File: rtl/tx_mac_axis_arbiter_if.sv
// AXI-Stream bundle used on every port of the TX arbiter.
// Signals: tdata, tkeep, tvalid, tlast (source -> sink), tready (sink -> source).
// Modports:
//   master : the side that sources beats (drives tdata/tkeep/tvalid/tlast)
//   slave  : the side that sinks beats (drives tready)
interface tx_mac_axis_arbiter_if
  import mac_pkg::*;
#(
  parameter int DATA_WIDTH = AXIS_DATA_W,
  parameter int KEEP_WIDTH = AXIS_KEEP_W
);

  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tvalid;
  logic                  tlast;
  logic                  tready;

  modport master (output tdata, tkeep, tvalid, tlast, input tready);
  modport slave  (input tdata, tkeep, tvalid, tlast, output tready);

endinterface

// File: rtl/tx_mac_axis_arbiter_rr_arb2.sv
// Combinational two-way round-robin pick.
// Ports:
//   i_valid  : request vector, bit N = requester N has a beat waiting
//   i_rr_ptr : requester that wins when both request (0 or 1)
//   o_grant  : one-hot winner, 00 when nobody requests
module rr_arb2 (
  input  logic [1:0] i_valid,
  input  logic       i_rr_ptr,
  output logic [1:0] o_grant
);

  always_comb begin
    o_grant = 2'b00;
    case (i_valid)
      2'b01:   o_grant = 2'b01;
      2'b10:   o_grant = 2'b10;
      2'b11:   o_grant = i_rr_ptr ? 2'b10 : 2'b01;
      default: o_grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/tx_mac_axis_arbiter.sv
// Packet-granular round-robin arbiter in front of the TX MAC AXI-Stream input.
// A requester owns the output from its first accepted beat through tlast; after
// each frame the output is held idle for IFG_CYCLES cycles so the MAC can append
// CRC and honour the inter-frame gap.
// Ports:
//   i_clk, i_reset : clock and synchronous active-high reset
//   s0_axis        : requester 0 stream (slave side)
//   s1_axis        : requester 1 stream (slave side)
//   m_axis         : stream towards the TX MAC (master side)
//   o_grant        : one-hot current owner, 00 when no owner
//   o_busy         : high while a frame or its idle gap is in progress
module tx_mac_axis_arbiter
  import mac_pkg::*;
#(
  parameter int DATA_WIDTH = AXIS_DATA_W,
  parameter int KEEP_WIDTH = AXIS_KEEP_W,
  parameter int IFG_CYCLES = TX_IFG_WORDS
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  tx_mac_axis_arbiter_if.slave        s0_axis,
  tx_mac_axis_arbiter_if.slave        s1_axis,
  tx_mac_axis_arbiter_if.master       m_axis,
  output logic [1:0]                  o_grant,
  output logic                        o_busy
);

  localparam logic [3:0] GAP_LOAD = 4'(IFG_CYCLES);

  arb_state_t r_state;
  logic [1:0] r_grant;
  logic       r_rr_ptr;
  logic [3:0] r_gap_cnt;

  logic [1:0] w_pick;
  logic       w_xfer;
  logic       w_last_hs;

  rr_arb2 u_rr_arb2 (
    .i_valid  ({s1_axis.tvalid, s0_axis.tvalid}),
    .i_rr_ptr (r_rr_ptr),
    .o_grant  (w_pick)
  );

  assign w_xfer = (r_state == XFER);

  // Output mux: only the owner is connected, and only during XFER. Everything
  // else is forced to zero so the MAC never sees stale data between frames.
  always_comb begin
    m_axis.tdata   = '0;
    m_axis.tkeep   = '0;
    m_axis.tvalid  = 1'b0;
    m_axis.tlast   = 1'b0;
    s0_axis.tready = 1'b0;
    s1_axis.tready = 1'b0;
    if (w_xfer) begin
      if (r_grant[1]) begin
        m_axis.tdata   = s1_axis.tdata;
        m_axis.tkeep   = s1_axis.tkeep;
        m_axis.tvalid  = s1_axis.tvalid;
        m_axis.tlast   = s1_axis.tlast;
        s1_axis.tready = m_axis.tready;
      end else begin
        m_axis.tdata   = s0_axis.tdata;
        m_axis.tkeep   = s0_axis.tkeep;
        m_axis.tvalid  = s0_axis.tvalid;
        m_axis.tlast   = s0_axis.tlast;
        s0_axis.tready = m_axis.tready;
      end
    end
  end

  // Frame ends only on an accepted beat carrying the owner's tlast.
  assign w_last_hs = w_xfer & m_axis.tvalid & m_axis.tready & m_axis.tlast;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= IDLE;
      r_grant   <= 2'b00;
      r_rr_ptr  <= 1'b0;
      r_gap_cnt <= 4'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|w_pick) begin
            r_grant <= w_pick;
            r_state <= XFER;
          end
        end
        XFER: begin
          if (w_last_hs) begin
            // r_grant[1] is the owner's index; the other requester gets priority next.
            r_rr_ptr <= ~r_grant[1];
            r_grant  <= 2'b00;
            if (IFG_CYCLES > 0) begin
              r_gap_cnt <= GAP_LOAD;
              r_state   <= GAP;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        GAP: begin
          // Counts wall-clock cycles; MAC backpressure does not extend the gap.
          r_gap_cnt <= r_gap_cnt - 4'd1;
          if (r_gap_cnt == 4'd1) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_grant <= 2'b00;
        end
      endcase
    end
  end

  assign o_grant = r_grant;
  assign o_busy  = (r_state != IDLE);

endmodule

// File: tb/tb_tx_mac_axis_arbiter.sv
// Self-checking bench for tx_mac_axis_arbiter.
// Two instances: index 0 with the default idle gap, index 1 with IFG_CYCLES=0.
// Sources are modelled as queues of frames with optional bubbles; the reference
// model tracks frame ownership, round-robin order and the idle gap in cycle
// numbers and compares every output each cycle.
module tb_tx_mac_axis_arbiter;
  import mac_pkg::*;

  localparam int DW    = AXIS_DATA_W;
  localparam int KW    = AXIS_KEEP_W;
  localparam int IFG_A = TX_IFG_WORDS;
  localparam int IFG_B = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // bench-driven inputs, [dut][source]
  logic [DW-1:0] d_tdata  [2][2];
  logic [KW-1:0] d_tkeep  [2][2];
  logic          d_tvalid [2][2];
  logic          d_tlast  [2][2];
  logic          d_mready [2];

  // observed outputs
  logic [1:0]    o_sready [2];
  logic [DW-1:0] m_tdata  [2];
  logic [KW-1:0] m_tkeep  [2];
  logic          m_tvalid [2];
  logic          m_tlast  [2];
  logic [1:0]    o_grant  [2];
  logic          o_busy   [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    tx_mac_axis_arbiter_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW)) s0_if ();
    tx_mac_axis_arbiter_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW)) s1_if ();
    tx_mac_axis_arbiter_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW)) m_if ();

    assign s0_if.tdata  = d_tdata[gi][0];
    assign s0_if.tkeep  = d_tkeep[gi][0];
    assign s0_if.tvalid = d_tvalid[gi][0];
    assign s0_if.tlast  = d_tlast[gi][0];
    assign s1_if.tdata  = d_tdata[gi][1];
    assign s1_if.tkeep  = d_tkeep[gi][1];
    assign s1_if.tvalid = d_tvalid[gi][1];
    assign s1_if.tlast  = d_tlast[gi][1];
    assign m_if.tready  = d_mready[gi];

    assign o_sready[gi] = {s1_if.tready, s0_if.tready};
    assign m_tdata[gi]  = m_if.tdata;
    assign m_tkeep[gi]  = m_if.tkeep;
    assign m_tvalid[gi] = m_if.tvalid;
    assign m_tlast[gi]  = m_if.tlast;

    tx_mac_axis_arbiter #(
      .DATA_WIDTH (DW),
      .KEEP_WIDTH (KW),
      .IFG_CYCLES ((gi == 0) ? IFG_A : IFG_B)
    ) u_dut (
      .i_clk   (clk),
      .i_reset (rst),
      .s0_axis (s0_if),
      .s1_axis (s1_if),
      .m_axis  (m_if),
      .o_grant (o_grant[gi]),
      .o_busy  (o_busy[gi])
    );
  end

  // reference model state
  axi_stream_t src_q [2][$];
  int  served[$];
  int  hs_cyc[$];
  bit  held [2];
  int  bubble_pct [2];
  int  pause_at [2];
  int  pause_left [2];
  int  rdy_mode;
  int  owner, last_served, idle_from, cyc;
  int  vectors, miscompares;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic load_frame(input int s, input int len, input logic [KW-1:0] last_keep);
    axi_stream_t b;
    for (int i = 0; i < len; i++) begin
      b.tdata = $urandom;
      b.tkeep = (i == len - 1) ? last_keep : {KW{1'b1}};
      b.tlast = (i == len - 1);
      src_q[s].push_back(b);
    end
  endtask

  task automatic drive(input int d);
    for (int s = 0; s < 2; s++) begin
      logic v;
      v = 1'b0;
      if (src_q[s].size() > 0) begin
        if (held[s]) v = 1'b1;
        else if (pause_left[s] > 0 && src_q[s].size() == pause_at[s]) pause_left[s]--;
        else v = (int'($urandom_range(99)) >= bubble_pct[s]);
      end
      d_tvalid[d][s] = v;
      if (v) begin
        d_tdata[d][s] = src_q[s][0].tdata;
        d_tkeep[d][s] = src_q[s][0].tkeep;
        d_tlast[d][s] = src_q[s][0].tlast;
      end else begin
        d_tdata[d][s] = $urandom;
        d_tkeep[d][s] = KW'($urandom);
        d_tlast[d][s] = 1'($urandom);
      end
    end
    case (rdy_mode)
      0:       d_mready[d] = 1'b1;
      1:       d_mready[d] = cyc[0];
      default: d_mready[d] = ($urandom_range(99) < 70);
    endcase
  endtask

  // One clock cycle: drive, compare against the model, advance the model.
  task automatic step(input int d, input int ifg);
    int hs;
    int nxt;
    logic [1:0] exp_g;
    axi_stream_t b;
    drive(d);
    @(negedge clk);
    hs  = -1;
    nxt = -1;
    if (owner < 0) begin
      check("idle_m_out", 64'({m_tvalid[d], m_tdata[d], m_tkeep[d], m_tlast[d]}), 64'(0));
      check("idle_grant", 64'(o_grant[d]), 64'(0));
      check("idle_sready", 64'(o_sready[d]), 64'(0));
      check("busy_gap", 64'(o_busy[d]), 64'(cyc < idle_from));
      if (cyc >= idle_from && (d_tvalid[d][0] || d_tvalid[d][1]))
        nxt = (d_tvalid[d][0] && d_tvalid[d][1]) ? 1 - last_served : (d_tvalid[d][1] ? 1 : 0);
    end else begin
      exp_g = (owner == 1) ? 2'b10 : 2'b01;
      check("xfer_grant", 64'(o_grant[d]), 64'(exp_g));
      check("xfer_busy", 64'(o_busy[d]), 64'(1));
      check("owner_ready", 64'(o_sready[d][owner]), 64'(d_mready[d]));
      check("other_ready", 64'(o_sready[d][1 - owner]), 64'(0));
      check("m_tvalid", 64'(m_tvalid[d]), 64'(d_tvalid[d][owner]));
      if (d_tvalid[d][owner]) begin
        check("m_beat", 64'({m_tdata[d], m_tkeep[d], m_tlast[d]}), 64'(src_q[owner][0]));
        if (d_mready[d]) hs = owner;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int s = 0; s < 2; s++) held[s] = d_tvalid[d][s] && (hs != s);
    if (hs >= 0) begin
      b = src_q[hs].pop_front();
      hs_cyc.push_back(cyc - 1);
      if (b.tlast) begin
        served.push_back(hs);
        last_served = hs;
        owner       = -1;
        idle_from   = cyc + ifg;
      end
    end
    if (nxt >= 0) owner = nxt;
  endtask

  task automatic run(input int d, input int ifg, input int budget, input string tag);
    int n;
    n = 0;
    while ((src_q[0].size() > 0 || src_q[1].size() > 0 || owner >= 0 || cyc <= idle_from)
           && n < budget) begin
      step(d, ifg);
      n++;
    end
    check({tag, "_timeout"}, 64'(n < budget), 64'(1));
  endtask

  // Reset is applied with the sources left as they were (possibly mid-frame).
  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc++;
    for (int k = 0; k < 2; k++) begin
      for (int s = 0; s < 2; s++) d_tvalid[k][s] = 1'b0;
      d_mready[k] = 1'b0;
    end
    owner = -1; last_served = 1; idle_from = cyc;
    held = '{0, 0};
    pause_left = '{0, 0};
    src_q[0].delete(); src_q[1].delete();
    served.delete(); hs_cyc.delete();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check("rst_m_out", 64'({m_tvalid[k], m_tdata[k], m_tkeep[k], m_tlast[k]}), 64'(0));
      check("rst_grant", 64'(o_grant[k]), 64'(0));
      check("rst_busy", 64'(o_busy[k]), 64'(0));
      check("rst_sready", 64'(o_sready[k]), 64'(0));
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    vectors = 0; miscompares = 0; cyc = 0; rdy_mode = 0;
    bubble_pct = '{0, 0};
    pause_at = '{0, 0};
    for (int k = 0; k < 2; k++) begin
      for (int s = 0; s < 2; s++) begin
        d_tdata[k][s] = '0; d_tkeep[k][s] = '0; d_tvalid[k][s] = 1'b0; d_tlast[k][s] = 1'b0;
      end
      d_mready[k] = 1'b0;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    do_reset();
    for (int i = 0; i < 3; i++) step(0, IFG_A);

    // single source, 16 words, last word tkeep=3
    load_frame(0, 16, 4'h3);
    run(0, IFG_A, 100, "single");
    check("single_frames", 64'(served.size()), 64'(1));

    // contention: both sources hold two 4-word frames each
    do_reset();
    load_frame(0, 4, 4'hF); load_frame(0, 4, 4'hF);
    load_frame(1, 4, 4'hF); load_frame(1, 4, 4'hF);
    run(0, IFG_A, 200, "contend");
    check("contend_n", 64'(served.size()), 64'(4));
    for (int i = 0; i < 4 && i < served.size(); i++)
      check("contend_order", 64'(served[i]), 64'(i % 2));

    // backpressure: MAC ready toggles during an s1 frame
    rdy_mode = 1;
    load_frame(1, 6, 4'h7);
    run(0, IFG_A, 100, "backpr");
    rdy_mode = 0;

    // source bubble: s0 stalls 5 cycles mid-frame while s1 waits
    served.delete();
    pause_at[0] = 5; pause_left[0] = 5;
    load_frame(0, 8, 4'hF);
    load_frame(1, 4, 4'h1);
    run(0, IFG_A, 200, "bubble");
    check("bubble_n", 64'(served.size()), 64'(2));
    if (served.size() == 2) begin
      check("bubble_first", 64'(served[0]), 64'(0));
      check("bubble_second", 64'(served[1]), 64'(1));
    end

    // randomized traffic: random lengths, bubbles and MAC backpressure
    bubble_pct = '{30, 30};
    rdy_mode = 2;
    for (int f = 0; f < 5; f++) begin
      load_frame(0, $urandom_range(1, 6), KW'((1 << $urandom_range(1, 4)) - 1));
      load_frame(1, $urandom_range(1, 6), KW'((1 << $urandom_range(1, 4)) - 1));
    end
    run(0, IFG_A, 2000, "random");
    bubble_pct = '{0, 0};
    rdy_mode = 0;

    // reset while s1 presents beat 5 of 8
    do_reset();
    load_frame(1, 8, 4'hF);
    n = 0;
    while (src_q[1].size() > 4 && n < 40) begin
      step(0, IFG_A);
      n++;
    end
    check("midrst_reach", 64'(n < 40), 64'(1));
    do_reset();
    load_frame(0, 2, 4'hF);
    load_frame(1, 2, 4'hF);
    run(0, IFG_A, 100, "postrst");
    check("postrst_n", 64'(served.size()), 64'(2));
    if (served.size() == 2) check("postrst_first", 64'(served[0]), 64'(0));

    // zero-gap build: back-to-back single-beat frames from s0
    do_reset();
    for (int f = 0; f < 6; f++) load_frame(0, 1, 4'hF);
    run(1, IFG_B, 100, "ifg0");
    check("ifg0_n", 64'(hs_cyc.size()), 64'(6));
    for (int i = 1; i < hs_cyc.size(); i++)
      check("ifg0_spacing", 64'(hs_cyc[i] - hs_cyc[i - 1]), 64'(2));

    // zero-gap build, both sources: round-robin flips every frame
    do_reset();
    for (int f = 0; f < 3; f++) begin
      load_frame(0, 1, 4'h1);
      load_frame(1, 1, 4'h3);
    end
    run(1, IFG_B, 100, "ifg0rr");
    check("ifg0rr_n", 64'(served.size()), 64'(6));
    for (int i = 0; i < served.size(); i++)
      check("ifg0rr_order", 64'(served[i]), 64'(i % 2));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
